mdu_iterative: RTL and testbench

Multi-cycle unsigned multiply/divide unit sitting between the register file read ports and the register file write port. It latches two operands read from the register file, runs a 32-step shift-add multiply or restoring divide, then presents a one-cycle write-back (W_reg/W_data/W_en) that drives the register file write port directly. The pipeline stalls on busy.

---
 rtl/mdu_iterative.sv | 147 ++++++++++++++
 tb/tb_mdu_iterative.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iterative.sv
// rtl/mdu_iterative.sv - iterative 32-bit unsigned multiply/divide unit with register-file write-back
module mdu_iterative #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [4:0]      dest,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [4:0]      W_reg,
    output logic [XLEN-1:0] W_data,
    output logic            W_en
);

    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] opd_q, opd_d;
    logic [XLEN:0]   hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [4:0]      dest_q, dest_d;
    logic            done_q, done_d;
    logic            w_en_q, w_en_d;
    logic [4:0]      w_reg_q, w_reg_d;
    logic [XLEN-1:0] w_data_q, w_data_d;

    logic [XLEN:0]   mul_add;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_sh;
    logic            div_ge;
    logic [XLEN:0]   div_rem;
    logic [XLEN:0]   step_hi;
    logic [XLEN-1:0] step_lo;
    logic [XLEN-1:0] result;

    // hi/lo is shared: {product high, multiplier/product low} for MUL,
    // {partial remainder, dividend/quotient} for DIV.
    always_comb begin
        mul_add = lo_q[0] ? {1'b0, opd_q} : {(XLEN+1){1'b0}};
        mul_sum = {1'b0, hi_q[XLEN-1:0]} + mul_add;
        div_sh  = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
        div_ge  = (div_sh >= {1'b0, opd_q});
        div_rem = div_ge ? (div_sh - {1'b0, opd_q}) : div_sh;

        if (op_q[1]) begin
            step_hi = div_rem;
            step_lo = {lo_q[XLEN-2:0], div_ge};
        end else begin
            step_hi = {1'b0, mul_sum[XLEN:1]};
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        result = op_q[0] ? step_hi[XLEN-1:0] : step_lo;

        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opd_d    = opd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dest_d   = dest_q;
        done_d   = 1'b0;
        w_en_d   = 1'b0;
        w_reg_d  = w_reg_q;
        w_data_d = w_data_q;

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    op_d    = op;
                    opd_d   = op[1] ? src_b : src_a;
                    lo_d    = op[1] ? src_a : src_b;
                    hi_d    = {(XLEN+1){1'b0}};
                    dest_d  = dest;
                    cnt_d   = {CW{1'b0}};
                    state_d = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(ITER - 1)) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        w_en_d   = (dest_q != 5'd0);
                        w_reg_d  = dest_q;
                        w_data_d = result;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= {CW{1'b0}};
            op_q     <= 2'd0;
            opd_q    <= {XLEN{1'b0}};
            hi_q     <= {(XLEN+1){1'b0}};
            lo_q     <= {XLEN{1'b0}};
            dest_q   <= 5'd0;
            done_q   <= 1'b0;
            w_en_q   <= 1'b0;
            w_reg_q  <= 5'd0;
            w_data_q <= {XLEN{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opd_q    <= opd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dest_q   <= dest_d;
            done_q   <= done_d;
            w_en_q   <= w_en_d;
            w_reg_q  <= w_reg_d;
            w_data_q <= w_data_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign W_en   = w_en_q;
    assign W_reg  = w_reg_q;
    assign W_data = w_data_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// tb/tb_mdu_iterative.sv - directed self-checking bench for mdu_iterative
module tb_mdu_iterative;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic [4:0]  dest = 5'd0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [4:0]  W_reg;
    logic [31:0] W_data;
    logic        W_en;

    int checks = 0;
    int errors = 0;

    mdu_iterative dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .dest   (dest),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .W_reg  (W_reg),
        .W_data (W_data),
        .W_en   (W_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int n);
        n = 41;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic accept(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d);
        op    = o;
        src_a = a;
        src_b = b;
        dest  = d;
        start = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        src_a = 32'hDEAD_BEEF;
        src_b = 32'h0BAD_F00D;
        dest  = 5'd17;
        check("accept_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] d,
                          input logic [31:0] exp_data, input logic exp_wen);
        int n;
        accept(o, a, b, d);
        wait_done(n);
        check({tag, "_lat"}, n, 32);
        check({tag, "_data"}, W_data, exp_data);
        check({tag, "_wen"}, {31'd0, W_en}, {31'd0, exp_wen});
        check({tag, "_wreg"}, {27'd0, W_reg}, {27'd0, d});
        @(posedge clk);
        #1;
        check({tag, "_done_clr"}, {31'd0, done}, 32'd0);
        check({tag, "_wen_clr"}, {31'd0, W_en}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        check({tag, "_hold"}, W_data, exp_data);
    endtask

    initial begin
        int n;
        logic saw;

        #3 reset = 1'b0;
        #9;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_wen", {31'd0, W_en}, 32'd0);
        check("rst_wreg", {27'd0, W_reg}, 32'd0);
        check("rst_wdata", W_data, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("mul7x6", 2'b00, 32'd7, 32'd6, 5'd5, 32'h0000_002A, 1'b1);
        run_op("mulhu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 1'b1);
        run_op("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0001, 1'b1);
        run_op("divu100_7", 2'b10, 32'd100, 32'd7, 5'd2, 32'h0000_000E, 1'b1);
        run_op("remu100_7", 2'b11, 32'd100, 32'd7, 5'd3, 32'h0000_0002, 1'b1);
        run_op("divu_z", 2'b10, 32'h1234_5678, 32'd0, 5'd31, 32'hFFFF_FFFF, 1'b1);
        run_op("remu_z", 2'b11, 32'h1234_5678, 32'd0, 5'd31, 32'h1234_5678, 1'b1);
        run_op("mul_r0", 2'b00, 32'd3, 32'd3, 5'd0, 32'h0000_0009, 1'b0);

        // A start raised mid-operation must not disturb or queue behind it.
        accept(2'b00, 32'd3, 32'd5, 5'd2);
        op    = 2'b10;
        src_a = 32'd100;
        src_b = 32'd7;
        dest  = 5'd9;
        start = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b0;
        check("ign_busy", {31'd0, busy}, 32'd1);
        wait_done(n);
        check("ign_lat", n, 27);
        check("ign_data", W_data, 32'd15);
        check("ign_wreg", {27'd0, W_reg}, 32'd2);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("ign_noqueue", {31'd0, busy}, 32'd0);

        accept(2'b10, 32'd100, 32'd7, 5'd3);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_idle", {31'd0, busy}, 32'd0);
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) saw = 1'b1;
        end
        check("flush_nodone", {31'd0, saw}, 32'd0);
        check("flush_wdata", W_data, 32'd15);
        run_op("divu9_3", 2'b10, 32'd9, 32'd3, 5'd4, 32'd3, 1'b1);

        accept(2'b00, 32'd7, 32'd6, 5'd5);
        repeat (10) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_wen", {31'd0, W_en}, 32'd0);
        check("arst_wreg", {27'd0, W_reg}, 32'd0);
        check("arst_wdata", W_data, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) saw = 1'b1;
        end
        check("arst_quiet", {31'd0, saw}, 32'd0);

        // Start held through DONE is taken only in the following IDLE cycle.
        accept(2'b01, 32'hFFFF_FFFF, 32'd2, 5'd6);
        wait_done(n);
        check("b2b_lat1", n, 32);
        check("b2b_data1", W_data, 32'd1);
        op    = 2'b00;
        src_a = 32'd4;
        src_b = 32'd5;
        dest  = 5'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("b2b_idle", {31'd0, busy}, 32'd0);
        check("b2b_done_clr", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_accept", {31'd0, busy}, 32'd1);
        wait_done(n);
        check("b2b_lat2", n, 32);
        check("b2b_data2", W_data, 32'd20);
        check("b2b_wreg2", {27'd0, W_reg}, 32'd7);
        check("b2b_wen2", {31'd0, W_en}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
